// File: rtl/cam_frame_writer_pkg.sv
// Shared constants and state encoding for the 320x240 RGB444 frame buffer
// (capture writer and display reader).
package cam_frame_writer_pkg;

    localparam int unsigned H_ACTIVE = 320;
    localparam int unsigned V_ACTIVE = 240;
    localparam int unsigned DATASIZE = 12;
    localparam int unsigned ADDRSIZE = 17;

    // Counter widths leave room for the saturation value itself
    localparam int unsigned X_W = $clog2(H_ACTIVE + 1);
    localparam int unsigned Y_W = $clog2(V_ACTIVE + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FRAME = 2'd2
    } cap_state_t;

endpackage

// File: rtl/cam_sync_edge.sv
// Registers vsync/href once and flags their transitions; pulses are combinational
// against the registered copy, so boundaries take effect on the following edge.
module cam_sync_edge
(
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vsync_rise_c,
    output logic vsync_fall_c,
    output logic href_fall_c
);

    logic vsync_q;
    logic href_q;

    // vsync_q resets high so a low vsync out of reset never looks like a fresh rise
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            href_q  <= href;
        end
    end

    assign vsync_rise_c = ~vsync_q & vsync;
    assign vsync_fall_c = vsync_q & ~vsync;
    assign href_fall_c  = href_q & ~href;

endmodule

// File: rtl/cam_frame_writer.sv
// Capture-side write stage: packs byte-serial RGB444 into 12-bit pixels and
// writes them to the frame buffer in raster order, flagging malformed frames.
module cam_frame_writer
    import cam_frame_writer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                continuous,
    input  logic                vsync,
    input  logic                href,
    input  logic                din_vld,
    input  logic [7:0]          din,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [DATASIZE-1:0] wdata,
    output logic                wr,
    output logic                busy,
    output logic                frame_done,
    output logic                frame_err
);

    cap_state_t state;
    cap_state_t state_nxt;

    logic vsync_rise_c;
    logic vsync_fall_c;
    logic href_fall_c;

    logic frame_start_c;
    logic frame_end_c;
    logic accept_c;
    logic pix_c;
    logic in_range_c;
    logic phase_nxt_c;
    logic line_used_c;

    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic                phase;
    logic [3:0]          red;
    logic                line_used;
    logic                shot_done;
    logic [ADDRSIZE-1:0] pix_addr;
    logic [ADDRSIZE-1:0] line_base;

    cam_sync_edge u_sync (
        .clk          (clk),
        .rst          (rst),
        .vsync        (vsync),
        .href         (href),
        .vsync_rise_c (vsync_rise_c),
        .vsync_fall_c (vsync_fall_c),
        .href_fall_c  (href_fall_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // shot_done keeps a single-shot capture idle until arm is released
    always_comb begin
        state_nxt     = state;
        frame_start_c = 1'b0;
        frame_end_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arm && !shot_done) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!arm) begin
                    state_nxt = ST_IDLE;
                end else if (vsync_fall_c) begin
                    state_nxt     = ST_FRAME;
                    frame_start_c = 1'b1;
                end
            end
            ST_FRAME: begin
                if (vsync_rise_c) begin
                    frame_end_c = 1'b1;
                    state_nxt   = (continuous && arm) ? ST_ARM : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept_c    = (state == ST_FRAME) && href && din_vld && !vsync;
    assign pix_c       = accept_c && phase;
    assign in_range_c  = (x < X_W'(H_ACTIVE)) && (y < Y_W'(V_ACTIVE));
    assign phase_nxt_c = phase ^ accept_c;
    assign line_used_c = line_used | accept_c;

    // Pixel packing, raster counters and incremental address; line end is applied
    // after any byte accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr      <= '0;
            wdata      <= '0;
            wr         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            red        <= '0;
            line_used  <= 1'b0;
            shot_done  <= 1'b0;
            pix_addr   <= '0;
            line_base  <= '0;
        end else begin
            wr         <= 1'b0;
            frame_done <= frame_end_c;
            busy       <= (state_nxt == ST_FRAME);

            if (!arm) begin
                shot_done <= 1'b0;
            end else if (frame_end_c && !continuous) begin
                shot_done <= 1'b1;
            end

            if (frame_start_c) begin
                x         <= '0;
                y         <= '0;
                phase     <= 1'b0;
                line_used <= 1'b0;
                frame_err <= 1'b0;
                pix_addr  <= '0;
                line_base <= '0;
            end else if (state == ST_FRAME) begin
                if (accept_c && !phase) begin
                    red <= din[3:0];
                end
                if (pix_c) begin
                    if (in_range_c) begin
                        wr       <= 1'b1;
                        waddr    <= pix_addr;
                        wdata    <= {red, din};
                        pix_addr <= pix_addr + ADDRSIZE'(1);
                    end else begin
                        frame_err <= 1'b1;
                    end
                    if (x < X_W'(H_ACTIVE)) begin
                        x <= x + X_W'(1);
                    end
                end
                phase     <= phase_nxt_c;
                line_used <= line_used_c;

                if (href_fall_c) begin
                    x         <= '0;
                    phase     <= 1'b0;
                    line_used <= 1'b0;
                    if (phase_nxt_c) begin
                        frame_err <= 1'b1;
                    end
                    if (line_used_c && (y < Y_W'(V_ACTIVE))) begin
                        y         <= y + Y_W'(1);
                        line_base <= line_base + ADDRSIZE'(H_ACTIVE);
                        pix_addr  <= line_base + ADDRSIZE'(H_ACTIVE);
                    end else begin
                        pix_addr  <= line_base;
                    end
                end

                // Half pixel still pending when the frame closes
                if (frame_end_c && phase_nxt_c) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer: scripted frames/lines, write scoreboard
// built from the stimulus, and aggregate checks per scenario.
module tb_cam_frame_writer;
    import cam_frame_writer_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                arm;
    logic                continuous;
    logic                vsync;
    logic                href;
    logic                din_vld;
    logic [7:0]          din;
    logic [ADDRSIZE-1:0] waddr;
    logic [DATASIZE-1:0] wdata;
    logic                wr;
    logic                busy;
    logic                frame_done;
    logic                frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    int          exp_addr_q[$];
    logic [11:0] exp_data_q[$];
    logic        err_hist[$];
    int          wr_cnt;
    int          done_cnt;
    int          addr_bad;
    int          data_bad;
    int          extra_wr;
    int          last_waddr;
    int          by;

    always #5 clk = ~clk;

    cam_frame_writer dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .continuous (continuous),
        .vsync      (vsync),
        .href       (href),
        .din_vld    (din_vld),
        .din        (din),
        .waddr      (waddr),
        .wdata      (wdata),
        .wr         (wr),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write scoreboard and frame_done log, sampled on the falling edge
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (wr === 1'b1) begin
                wr_cnt++;
                last_waddr = int'(waddr);
                if (exp_addr_q.size() == 0) begin
                    extra_wr++;
                end else begin
                    if (int'(waddr) != exp_addr_q.pop_front()) addr_bad++;
                    if (wdata !== exp_data_q.pop_front()) data_bad++;
                end
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                err_hist.push_back(frame_err);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic err_at(input int i);
        return (err_hist.size() > i) ? err_hist[i] : 1'bx;
    endfunction

    task automatic clear_stats();
        exp_addr_q.delete();
        exp_data_q.delete();
        err_hist.delete();
        wr_cnt     = 0;
        done_cnt   = 0;
        addr_bad   = 0;
        data_bad   = 0;
        extra_wr   = 0;
        last_waddr = -1;
    endtask

    task automatic frame_open();
        vsync = 1'b1;
        repeat (4) @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        by = 0;
    endtask

    task automatic frame_close();
        vsync = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // One accepted byte; the bench's raster model predicts the write for phase-1 bytes
    task automatic send_byte(input int k, input logic [7:0] b0, input logic [7:0] b1,
                             input bit expect_wr);
        int pix;
        pix     = k / 2;
        href    = 1'b1;
        din_vld = 1'b1;
        din     = (k % 2 == 0) ? b0 : b1;
        if (expect_wr && (k % 2 == 1) && (pix < 320) && (by < 240)) begin
            exp_addr_q.push_back(by * 320 + pix);
            exp_data_q.push_back({b0[3:0], b1});
        end
        @(negedge clk);
    endtask

    task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input bit expect_wr, input bit gaps);
        for (int k = 0; k < n; k++) begin
            send_byte(k, b0, b1, expect_wr);
            if (gaps) begin
                din_vld = 1'b0;
                din     = 8'hFF;
                @(negedge clk);
            end
        end
        href    = 1'b0;
        din_vld = 1'b0;
        if (n > 0) by++;
        repeat (3) @(negedge clk);
    endtask

    task automatic disarm();
        arm = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; continuous = 1'b0;
        vsync = 1'b1; href = 1'b0; din_vld = 1'b0; din = 8'h00;
        by = 0;
        clear_stats();
        repeat (3) @(negedge clk);
        check("rst_waddr",      32'(waddr),      32'd0);
        check("rst_wdata",      32'(wdata),      32'd0);
        check("rst_wr",         32'(wr),         32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_state",      32'(dut.state),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Raster order and packing over full lines, one line with strobe gaps
        clear_stats();
        arm = 1'b1;
        frame_open();
        check("t1_busy_in_frame", 32'(busy), 32'd1);
        for (int l = 0; l < 3; l++) send_line(640, 8'h0A, 8'hBC, 1'b1, 1'b0);
        send_line(640, 8'hF5, 8'h3E, 1'b1, 1'b1);
        frame_close();
        check("t1_wr_cnt",    32'(wr_cnt),            32'd1280);
        check("t1_addr_bad",  32'(addr_bad),          32'd0);
        check("t1_data_bad",  32'(data_bad),          32'd0);
        check("t1_extra_wr",  32'(extra_wr),          32'd0);
        check("t1_missing",   32'(exp_addr_q.size()), 32'd0);
        check("t1_last_addr", 32'(last_waddr),        32'd1279);
        check("t1_done_cnt",  32'(done_cnt),          32'd1);
        check("t1_err",       32'(err_at(0)),         32'd0);
        check("t1_busy_idle", 32'(busy),              32'd0);
        disarm();

        // Over-long odd line: extra pixel dropped, half pixel discarded
        clear_stats();
        arm = 1'b1;
        frame_open();
        send_line(643, 8'h0A, 8'hBC, 1'b1, 1'b0);
        send_line(4, 8'h01, 8'h23, 1'b1, 1'b0);
        frame_close();
        check("t2_wr_cnt",    32'(wr_cnt),            32'd322);
        check("t2_addr_bad",  32'(addr_bad),          32'd0);
        check("t2_data_bad",  32'(data_bad),          32'd0);
        check("t2_extra_wr",  32'(extra_wr),          32'd0);
        check("t2_missing",   32'(exp_addr_q.size()), 32'd0);
        check("t2_last_addr", 32'(last_waddr),        32'd321);
        check("t2_err",       32'(err_at(0)),         32'd1);
        disarm();

        // 245 lines: last line in range is full, lines beyond 240 are dropped
        clear_stats();
        arm = 1'b1;
        frame_open();
        for (int l = 0; l < 239; l++) send_line(2, 8'h0A, 8'hBC, 1'b1, 1'b0);
        send_line(640, 8'h0A, 8'hBC, 1'b1, 1'b0);
        for (int l = 0; l < 5; l++) send_line(2, 8'h0A, 8'hBC, 1'b1, 1'b0);
        frame_close();
        check("t3_wr_cnt",    32'(wr_cnt),            32'd559);
        check("t3_addr_bad",  32'(addr_bad),          32'd0);
        check("t3_extra_wr",  32'(extra_wr),          32'd0);
        check("t3_missing",   32'(exp_addr_q.size()), 32'd0);
        check("t3_last_addr", 32'(last_waddr),        32'd76799);
        check("t3_err",       32'(err_at(0)),         32'd1);
        disarm();

        // Single shot: arm held across three vsync periods captures only the first
        clear_stats();
        arm = 1'b1;
        continuous = 1'b0;
        frame_open();
        send_line(4, 8'h0A, 8'hBC, 1'b1, 1'b0);
        send_line(4, 8'h0A, 8'hBC, 1'b1, 1'b0);
        frame_close();
        for (int f = 0; f < 2; f++) begin
            frame_open();
            send_line(4, 8'h0A, 8'hBC, 1'b0, 1'b0);
            frame_close();
        end
        check("t4_done_cnt", 32'(done_cnt),  32'd1);
        check("t4_wr_cnt",   32'(wr_cnt),    32'd4);
        check("t4_addr_bad", 32'(addr_bad),  32'd0);
        check("t4_extra_wr", 32'(extra_wr),  32'd0);
        check("t4_busy",     32'(busy),      32'd0);
        check("t4_state",    32'(dut.state), 32'd0);
        disarm();

        // Continuous: second frame restarts at address 0 and clears the error
        clear_stats();
        arm = 1'b1;
        continuous = 1'b1;
        frame_open();
        send_line(3, 8'h07, 8'h89, 1'b1, 1'b0);
        frame_close();
        frame_open();
        check("t5_err_cleared", 32'(frame_err), 32'd0);
        check("t5_busy",        32'(busy),      32'd1);
        send_line(4, 8'h0C, 8'hDE, 1'b1, 1'b0);
        arm = 1'b0;
        frame_close();
        check("t5_done_cnt",  32'(done_cnt),            32'd2);
        check("t5_err0",      32'(err_at(0)),           32'd1);
        check("t5_err1",      32'(err_at(1)),           32'd0);
        check("t5_wr_cnt",    32'(wr_cnt),              32'd3);
        check("t5_addr_bad",  32'(addr_bad),            32'd0);
        check("t5_data_bad",  32'(data_bad),            32'd0);
        check("t5_missing",   32'(exp_addr_q.size()),   32'd0);
        check("t5_state",     32'(dut.state),           32'd0);
        continuous = 1'b0;
        disarm();

        // Reset at line 100, pixel 50, then re-arm and a fresh vsync fall
        clear_stats();
        arm = 1'b1;
        frame_open();
        for (int l = 0; l < 100; l++) send_line(2, 8'h0A, 8'hBC, 1'b1, 1'b0);
        for (int k = 0; k < 101; k++) send_byte(k, 8'h0A, 8'hBC, 1'b1);
        rst = 1'b1; href = 1'b1; din_vld = 1'b1; din = 8'hBC;
        @(negedge clk);
        check("t6_rst_wr",    32'(wr),                32'd0);
        check("t6_rst_waddr", 32'(waddr),             32'd0);
        check("t6_rst_busy",  32'(busy),              32'd0);
        check("t6_rst_err",   32'(frame_err),         32'd0);
        check("t6_rst_queue", 32'(exp_addr_q.size()), 32'd0);
        rst = 1'b0; href = 1'b0; din_vld = 1'b0; arm = 1'b0;
        repeat (2) @(negedge clk);
        frame_open();
        send_line(4, 8'h0A, 8'hBC, 1'b0, 1'b0);
        arm = 1'b1;
        repeat (3) @(negedge clk);
        send_line(4, 8'h0A, 8'hBC, 1'b0, 1'b0);
        check("t6_no_done",  32'(done_cnt), 32'd0);
        check("t6_armed_wr", 32'(wr_cnt),   32'd150);
        frame_open();
        send_line(4, 8'h0A, 8'hBC, 1'b1, 1'b0);
        frame_close();
        check("t6_done_cnt",  32'(done_cnt),            32'd1);
        check("t6_wr_cnt",    32'(wr_cnt),              32'd152);
        check("t6_addr_bad",  32'(addr_bad),            32'd0);
        check("t6_extra_wr",  32'(extra_wr),            32'd0);
        check("t6_last_addr", 32'(last_waddr),          32'd1);
        check("t6_missing",   32'(exp_addr_q.size()),   32'd0);
        disarm();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Capture-side write stage of the 320x240 frame buffer. Accepts a byte-serial RGB444 camera stream (vsync/href/byte strobe, already sampled into the system clock domain), assembles 12-bit pixels and drives the frame-buffer write port (address, data, write enable) in raster order. It handles frame and line boundaries, drops out-of-range pixels, and flags malformed lines. It sits directly upstream of the frame-buffer RAM.

## Interface
- H_ACTIVE, 320, pixels per line written
- V_ACTIVE, 240, lines per frame written
- DATASIZE, 12, pixel width (must match frame buffer)
- ADDRSIZE, 17, write address width (must match frame buffer)

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- arm  in  1  level; 1 = capture enabled, 0 = stop at end of current frame
- continuous  in  1  1 = re-arm after every frame; 0 = capture one frame, then idle
- vsync  in  1  1 = vertical blanking; falling edge = frame start, rising edge = frame end
- href  in  1  1 = active line bytes
- din_vld  in  1  byte strobe; a byte is accepted only when href=1 and din_vld=1 in the same cycle
- din  in  8  camera byte
- waddr  out  ADDRSIZE  frame-buffer write address
- wdata  out  DATASIZE  frame-buffer write data
- wr  out  1  frame-buffer write enable, one cycle per pixel
- busy  out  1  1 while in FRAME state
- frame_done  out  1  one-cycle pulse at frame end
- frame_err  out  1  sticky error for the current or most recent frame

## Operation
- States: IDLE, ARM, FRAME.
- IDLE -> ARM when arm=1. ARM -> FRAME on vsync falling edge (registered vsync 1 -> 0); x, y, byte phase and frame_err clear on that edge. ARM -> IDLE if arm=0.
- FRAME -> on vsync rising edge: pulse frame_done; go to ARM if continuous=1 and arm=1, otherwise IDLE.
- Pixel assembly: phase 0 byte latches din[3:0] as R. Phase 1 byte forms wdata = {R, din[7:4], din[3:0]} = {R,G,B} and issues a write. Phase toggles on every accepted byte.
- Address: waddr = y*H_ACTIVE + x, maintained incrementally (no multiplier). Maximum is 76799.
- Write is issued only if x < H_ACTIVE and y < V_ACTIVE. Out-of-range pixels are dropped and set frame_err. x still increments, saturating at H_ACTIVE.
- Line end = href falling edge (registered href 1 -> 0):
  - x -> 0; phase -> 0.
  - y increments only if the line accepted at least one byte; y saturates at V_ACTIVE.
  - If phase = 1 at line end, the half pixel is discarded and frame_err is set.
- Bytes in ARM or IDLE are ignored. href/din_vld during vsync=1 are ignored.
- frame_err holds until the next frame start.

## Timing
- Reset values: waddr=0, wdata=0, wr=0, busy=0, frame_done=0, frame_err=0; state=IDLE, x=y=phase=0.
- Latency: phase-1 byte accepted in cycle t -> wr=1 with matching waddr/wdata in cycle t+1. All outputs are registered.
- Back-to-back din_vld every cycle is supported: at most one write per two cycles by construction.
- Edge detection uses one registered copy of vsync/href, so each boundary acts one cycle after the input transition.
- Simultaneous events:
  - A byte accepted in the same cycle the registered-edge logic sees href fall is still processed before the line end.
  - vsync rise with a pending phase-0 byte: the byte is discarded and frame_err is set.
- A write pending in cycle t+1 completes even if the frame ends in cycle t+1.
- rst mid-frame: all state clears next edge, wr=0 immediately after, and no frame_done is emitted.

## Structure
- Shared package/header: H_ACTIVE, V_ACTIVE, DATASIZE, ADDRSIZE defaults and state encodings (IDLE=0, ARM=1, FRAME=2); the frame-buffer reader uses the same constants.
- One natural sub-module: cam_sync_edge. It registers vsync/href and outputs rise/fall pulses.
- Counters, pixel packer and FSM stay in the top level.

## Test plan
- Full frame: 240 lines x 640 bytes, pixel n = byte pair (0x0A, 0xBC) -> 76800 writes, waddr 0..76799 in order, wdata=0xABC, one frame_done, frame_err=0.
- Line with 643 bytes -> writes x=0..319 only; the extra pixel is dropped and the odd byte is discarded; frame_err=1 at frame_done; the next line starts at waddr=320*(y+1).
- 245 lines -> last write waddr=76799, no writes for y>=240, frame_err=1.
- continuous=0, arm=1 for three vsync periods -> exactly one frame captured; busy=0 afterwards; state IDLE.
- continuous=1 -> two consecutive frames, each starting at waddr=0, frame_err cleared at the second frame start.
- rst asserted at line 100, pixel 50 -> next cycle wr=0, waddr=0, busy=0; no frame_done; capture resumes only after arm and a new vsync fall.
